// File: rtl/uart_tx.sv
// uart_tx: valid/ready UART serialiser. Bits are timed by rising edges of i_baud
// (a divided clock synchronous to i_clk). Frame: start, data LSB-first, optional
// parity, stop bit(s). Defining UART_TX_PARITY_EN adds the parity bit.
module uart_tx #(
    parameter int p_data_bits  = 8,
    parameter int p_stop_bits  = 1,
    parameter int p_parity_odd = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_baud,
    input  logic [p_data_bits-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_tx
);

    localparam int             BCW       = (p_data_bits > 1) ? $clog2(p_data_bits) : 1;
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(p_data_bits - 1);
    localparam logic           LAST_STOP = 1'(p_stop_bits - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_PEND, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_PEND, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 r_state;
    state_t                 w_state_nx;
    logic                   r_tx;
    logic                   w_tx_nx;
    logic                   r_ready;
    logic                   w_ready_nx;
    logic [BCW-1:0]         r_bit_cnt;
    logic [BCW-1:0]         w_bit_cnt_nx;
    logic                   r_stop_cnt;
    logic                   w_stop_cnt_nx;
    logic                   r_baud_q;
    logic                   w_tick;
    logic                   w_load;
    logic                   w_shift;
    logic [p_data_bits-1:0] r_shift;

`ifdef UART_TX_PARITY_EN
    logic                   r_parity;

    // Parity of the word being latched; odd parity inverts the even result.
    function automatic logic f_parity(input logic [p_data_bits-1:0] d);
        return (^d) ^ (p_parity_odd != 0);
    endfunction
`else
    logic                   w_unused_parity_cfg;
    assign w_unused_parity_cfg = (p_parity_odd != 0);
`endif

    // One-cycle pulse on each rising edge of the baud clock.
    assign w_tick  = i_baud & ~r_baud_q;
    assign o_ready = r_ready;
    assign o_busy  = ~r_ready;
    assign o_tx    = r_tx;

    // Control state, line driver and counters; reset puts the line back to idle at once.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_baud_q   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_tx       <= w_tx_nx;
            r_ready    <= w_ready_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_baud_q   <= i_baud;
        end
    end

    // Data word (and its parity) captured on acceptance, shifted right once per data bit.
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_shift  <= i_data;
`ifdef UART_TX_PARITY_EN
            r_parity <= f_parity(i_data);
`endif
        end else if (w_shift) begin
            r_shift  <= r_shift >> 1;
        end
    end

    // Next-state logic: acceptance in IDLE, every other transition waits for a baud tick.
    always_comb begin
        w_state_nx    = r_state;
        w_tx_nx       = r_tx;
        w_ready_nx    = r_ready;
        w_bit_cnt_nx  = r_bit_cnt;
        w_stop_cnt_nx = r_stop_cnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid && r_ready) begin
                    w_load     = 1'b1;
                    w_ready_nx = 1'b0;
                    w_state_nx = S_PEND;
                end
            end
            S_PEND: begin
                if (w_tick) begin
                    w_tx_nx    = 1'b0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_tx_nx      = r_shift[0];
                    w_bit_cnt_nx = '0;
                    w_state_nx   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nx       = r_parity;
                        w_state_nx    = S_PARITY;
`else
                        w_tx_nx       = 1'b1;
                        w_stop_cnt_nx = 1'b0;
                        w_state_nx    = S_STOP;
`endif
                    end else begin
                        w_tx_nx      = r_shift[1];
                        w_bit_cnt_nx = r_bit_cnt + BCW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_tx_nx       = 1'b1;
                    w_stop_cnt_nx = 1'b0;
                    w_state_nx    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_ready_nx = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_stop_cnt_nx = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_ready_nx = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized checks of the uart_tx line waveform.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int NB       = 8;
    localparam int NS       = 1;
    localparam int ODD      = 0;
    localparam int BAUD_DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif
    localparam int FLEN         = 1 + NB + NP + NS;
    localparam int START_BUDGET = 4 * BAUD_DIV;
    localparam int READY_BUDGET = 40 * BAUD_DIV;

    logic       clk     = 1'b0;
    logic       i_rst   = 1'b1;
    logic       i_baud  = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       o_ready;
    logic       o_busy;
    logic       o_tx;
    bit         stall   = 1'b0;
    int         checks  = 0;
    int         errors  = 0;
    int         last_wait = 0;

    typedef struct {
        logic [7:0] data;
        string      line;      // 8N1 line levels in transmission order
        bit         par_even;  // even parity of data
        string      name;
    } vec_t;

    vec_t vecs[$];

    uart_tx #(.p_data_bits(NB), .p_stop_bits(NS), .p_parity_odd(ODD)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_baud  (i_baud),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_tx    (o_tx)
    );

    initial forever #5 clk = ~clk;

    // Baud source: square wave of BAUD_DIV clocks, frozen while stall is set.
    initial begin : baud_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!stall) begin
                cnt    = (cnt + 1) % BAUD_DIV;
                i_baud = (cnt < BAUD_DIV / 2);
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame from the word: start 0, data LSB first, optional parity, stop 1s.
    function automatic logic [FLEN-1:0] model_frame(input logic [7:0] w);
        logic [FLEN-1:0] f;
        int idx;
        f   = '1;
        idx = 0;
        f[idx] = 1'b0;
        idx++;
        for (int i = 0; i < NB; i++) begin
            f[idx] = (((w >> i) & 8'd1) != 0);
            idx++;
        end
        if (NP == 1) begin
            f[idx] = (($countones(w) % 2) == 1) ^ (ODD != 0);
            idx++;
        end
        for (int i = 0; i < NS; i++) begin
            f[idx] = 1'b1;
            idx++;
        end
        return f;
    endfunction

    // Expected frame from a table row (hand-written 8N1 levels plus parity constant).
    function automatic logic [FLEN-1:0] table_frame(input string s, input bit par_even);
        logic [FLEN-1:0] f;
        int idx;
        f = '1;
        for (int i = 0; i < 1 + NB; i++) f[i] = (s[i] == "1");
        idx = 1 + NB;
        if (NP == 1) begin
            f[idx] = par_even ^ (ODD != 0);
            idx++;
        end
        for (int i = 0; i < NS; i++) f[idx + i] = (s[1 + NB] == "1");
        return f;
    endfunction

    // Offer a word and return on the negedge after it was taken.
    task automatic drive_word(input logic [7:0] w, input string name);
        int n;
        n       = 0;
        i_data  = w;
        i_valid = 1'b1;
        while (!o_ready && n < READY_BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk({name, " accept"}, {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Wait for the start edge, then require every bit to hold its level for a full period.
    task automatic check_frame(input logic [FLEN-1:0] exp, input string name);
        int bad;
        last_wait = 0;
        while (o_tx !== 1'b0 && last_wait < START_BUDGET) begin
            @(negedge clk);
            last_wait++;
        end
        if (o_tx !== 1'b0) begin
            chk({name, " start"}, {31'd0, o_tx}, 32'd0);
            return;
        end
        for (int b = 0; b < FLEN; b++) begin
            bad = 0;
            for (int c = 0; c < BAUD_DIV; c++) begin
                if (o_tx !== exp[b]) bad++;
                @(negedge clk);
            end
            chk($sformatf("%s bit%0d wrong-cycles", name, b), bad, 32'd0);
        end
        chk({name, " ready after"}, {31'd0, o_ready}, 32'd1);
        chk({name, " busy after"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin : main
        int low;
        int n;
        logic [7:0] w;
        logic [FLEN-1:0] fr;

        vecs.push_back('{8'hA5, "0101001011", 1'b0, "a5"});
        vecs.push_back('{8'h07, "0111000001", 1'b1, "07"});
        vecs.push_back('{8'h00, "0000000001", 1'b0, "00"});
        vecs.push_back('{8'hFF, "0111111111", 1'b0, "ff"});
        vecs.push_back('{8'h3C, "0001111001", 1'b0, "3c"});
        vecs.push_back('{8'h12, "0010010001", 1'b0, "12"});
        vecs.push_back('{8'h80, "0000000011", 1'b1, "80"});

        // Asynchronous reset between clock edges.
        #2 i_rst = 1'b0;
        #1;
        chk("reset tx", {31'd0, o_tx}, 32'd1);
        chk("reset ready", {31'd0, o_ready}, 32'd1);
        chk("reset busy", {31'd0, o_busy}, 32'd0);
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        repeat (2 * BAUD_DIV) @(negedge clk);
        chk("idle tx", {31'd0, o_tx}, 32'd1);

        // Table-driven frames.
        foreach (vecs[i]) begin
            drive_word(vecs[i].data, vecs[i].name);
            check_frame(table_frame(vecs[i].line, vecs[i].par_even), vecs[i].name);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Back-to-back with i_valid held high.
        fork
            begin
                drive_word(8'h00, "b2b0");
                drive_word(8'hFF, "b2b1");
            end
            begin
                check_frame(table_frame("0000000001", 1'b0), "b2b0");
                check_frame(table_frame("0111111111", 1'b0), "b2b1");
            end
        join
        checks++;
        if (last_wait > BAUD_DIV) begin
            errors++;
            $display("FAIL b2b gap: idle %0d cycles, allowed at most %0d", last_wait, BAUD_DIV);
        end

        // Reset during data bit 3 of 0xA5 (a 0 level), then a clean 0x3C frame.
        drive_word(8'hA5, "rst");
        n = 0;
        while (o_tx !== 1'b0 && n < START_BUDGET) begin
            @(negedge clk);
            n++;
        end
        repeat (BAUD_DIV * 4 + 5) @(negedge clk);
        chk("rst pre tx", {31'd0, o_tx}, 32'd0);
        #2 i_rst = 1'b0;
        #1;
        chk("rst mid tx", {31'd0, o_tx}, 32'd1);
        chk("rst mid ready", {31'd0, o_ready}, 32'd1);
        chk("rst mid busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        i_rst = 1'b1;
        low = 0;
        repeat (3 * BAUD_DIV) begin
            if (o_tx !== 1'b1) low++;
            @(negedge clk);
        end
        chk("rst no resume", low, 32'd0);
        drive_word(8'h3C, "post-rst");
        check_frame(table_frame("0001111001", 1'b0), "post-rst");

        // Stalled baud clock holds the current bit.
        drive_word(8'hC3, "stall");
        fr = model_frame(8'hC3);
        n = 0;
        while (o_tx !== 1'b0 && n < START_BUDGET) begin
            @(negedge clk);
            n++;
        end
        repeat (BAUD_DIV * 3 + 4) @(negedge clk);
        stall = 1'b1;
        low = 0;
        repeat (60) begin
            if (o_tx !== fr[3]) low++;
            @(negedge clk);
        end
        chk("stall hold", low, 32'd0);
        chk("stall busy", {31'd0, o_busy}, 32'd1);
        stall = 1'b0;
        n = 0;
        while (!o_ready && n < READY_BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("stall ready", {31'd0, o_ready}, 32'd1);
        repeat (BAUD_DIV) @(negedge clk);

        // i_valid pulse with 0xFF while 0x12 is in flight is ignored.
        fork
            begin
                drive_word(8'h12, "busy");
                repeat (60) @(negedge clk);
                i_data  = 8'hFF;
                i_valid = 1'b1;
                @(negedge clk);
                i_valid = 1'b0;
            end
            check_frame(table_frame("0010010001", 1'b0), "busy");
        join
        low = 0;
        repeat (3 * BAUD_DIV) begin
            if (o_tx !== 1'b1) low++;
            @(negedge clk);
        end
        chk("busy no extra frame", low, 32'd0);

        // Random words against the frame model.
        repeat (12) begin
            w = 8'($urandom_range(0, 255));
            drive_word(w, "rnd");
            check_frame(model_frame(w), $sformatf("rnd %02h", w));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
